// File: rtl/dma_rd_burst_ctrl.sv
// Read-side DMA burst controller: splits one (address, word-count) command
// into page-safe read bursts on a memory pseudo-channel, caps the number of
// bursts in flight and streams returned beats straight to a downstream sink.
module dma_rd_burst_ctrl #(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int WORD_BYTES      = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [32:0]             cmd_addr,
    input  logic [31:0]             cmd_words,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [32:0]             ar_addr,
    output logic [3:0]              ar_len,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [WORD_BYTES*8-1:0] r_data,
    input  logic                    r_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_BYTES*8-1:0] out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int         LP_SHIFT      = $clog2(WORD_BYTES);
    localparam logic [6:0] LP_PAGE_WORDS = 7'(4096 / WORD_BYTES);
    localparam logic [6:0] LP_MAX_BURST  = 7'(MAX_BURST);
    localparam logic [3:0] LP_MAX_OUT    = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_INIT,
        DMA_EXEC,
        DMA_DONE
    } dma_state_e;

    dma_state_e  r_state;
    logic [32:0] r_addr;          // address of the next burst to issue
    logic [31:0] r_issue_rem;     // words not yet requested
    logic [31:0] r_recv_rem;      // words not yet received
    logic [3:0]  r_outstanding;   // bursts requested but not closed by r_last
    logic        r_ar_valid;
    logic [3:0]  r_ar_len;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_in_exec;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_last_hs;
    logic [6:0]  w_cur_beats;
    logic [32:0] w_addr_nxt;
    logic [31:0] w_issue_nxt;
    logic [31:0] w_recv_nxt;
    logic [3:0]  w_out_nxt;
    logic [6:0]  w_nxt_beats;
    logic        w_unused_addr_lsbs;

    // Beats of the burst starting at addr: bounded by the burst limit, the
    // words still to request and the words left before the 4 KB page ends.
    function automatic logic [6:0] burst_beats(input logic [32:0] addr,
                                               input logic [31:0] rem);
        logic [6:0] room;
        logic [6:0] cap;
        logic [6:0] beats;
        room  = LP_PAGE_WORDS - 7'(addr[11:LP_SHIFT]);
        cap   = (rem > 32'(LP_PAGE_WORDS)) ? LP_PAGE_WORDS : rem[6:0];
        beats = LP_MAX_BURST;
        if (cap < beats) beats = cap;
        if (room < beats) beats = room;
        return beats;
    endfunction

    // ar_len encoding of a beat count; an empty burst parks at 0.
    function automatic logic [3:0] len_of(input logic [6:0] beats);
        return (beats == 7'd0) ? 4'd0 : 4'(beats - 7'd1);
    endfunction

    // Next-value computation for issue/receive bookkeeping in DMA_EXEC.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        w_in_exec   = (r_state == DMA_EXEC);
        w_ar_hs     = r_ar_valid && ar_ready;
        w_r_hs      = w_in_exec && r_valid && out_ready;
        w_last_hs   = w_r_hs && r_last;
        w_cur_beats = 7'(r_ar_len) + 7'd1;
        w_addr_nxt  = r_addr;
        w_issue_nxt = r_issue_rem;
        w_recv_nxt  = r_recv_rem;
        w_out_nxt   = r_outstanding;
        if (w_ar_hs) begin
            w_addr_nxt  = r_addr + (33'(w_cur_beats) << LP_SHIFT);
            w_issue_nxt = r_issue_rem - 32'(w_cur_beats);
        end
        if (w_r_hs && r_recv_rem != 32'd0) begin
            w_recv_nxt = r_recv_rem - 32'd1;
        end
        // A request and a burst completion in the same cycle cancel out.
        if (w_ar_hs && !w_last_hs) begin
            w_out_nxt = r_outstanding + 4'd1;
        end else if (!w_ar_hs && w_last_hs && r_outstanding != 4'd0) begin
            w_out_nxt = r_outstanding - 4'd1;
        end
        w_nxt_beats = burst_beats(w_addr_nxt, w_issue_nxt);
    end

    // Control FSM with all handshake/status outputs registered.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state       <= DMA_IDLE;
            r_addr        <= '0;
            r_issue_rem   <= '0;
            r_recv_rem    <= '0;
            r_outstanding <= '0;
            r_ar_valid    <= 1'b0;
            r_ar_len      <= '0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                DMA_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= {cmd_addr[32:LP_SHIFT], {LP_SHIFT{1'b0}}};
                        r_issue_rem <= cmd_words;
                        r_recv_rem  <= cmd_words;
                        r_err       <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= DMA_INIT;
                    end
                end
                DMA_INIT: begin
                    if (r_recv_rem == 32'd0) begin
                        r_done  <= 1'b1;
                        r_state <= DMA_DONE;
                    end else begin
                        r_ar_valid <= (r_outstanding < LP_MAX_OUT);
                        r_ar_len   <= len_of(burst_beats(r_addr, r_issue_rem));
                        r_state    <= DMA_EXEC;
                    end
                end
                DMA_EXEC: begin
                    r_addr        <= w_addr_nxt;
                    r_issue_rem   <= w_issue_nxt;
                    r_recv_rem    <= w_recv_nxt;
                    r_outstanding <= w_out_nxt;
                    r_ar_len      <= len_of(w_nxt_beats);
                    if (w_r_hs && r_outstanding == 4'd0) begin
                        r_err <= 1'b1;
                    end
                    if (w_recv_nxt == 32'd0) begin
                        r_ar_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DMA_DONE;
                    end else begin
                        r_ar_valid <= (w_issue_nxt != 32'd0) && (w_out_nxt < LP_MAX_OUT);
                    end
                end
                DMA_DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= DMA_IDLE;
                end
                default: r_state <= DMA_IDLE;
            endcase
        end
    end

    // Word-offset bits of the command address carry no meaning.
    assign w_unused_addr_lsbs = ^cmd_addr[LP_SHIFT-1:0];

    assign cmd_ready = r_cmd_ready;
    assign ar_valid  = r_ar_valid;
    assign ar_addr   = r_addr;
    assign ar_len    = r_ar_len;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    // Zero-latency read-data path, gated to DMA_EXEC.
    assign r_ready   = w_in_exec && out_ready;
    assign out_valid = w_in_exec && r_valid;
    assign out_data  = r_data;

endmodule
